// File: rtl/seq_mul_param.sv
// seq_mul_param: radix-2 shift-add sequential multiplier, W x W -> 2W.
// One product in flight; start/busy/done handshake; optional two's-complement
// mode handled by multiplying magnitudes and negating the result at the end.
module seq_mul_param #(
  parameter int W         = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     mcand;
  logic [2*W:0]     acc;   // {carry, upper, lower}
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             sm;
  logic [W-1:0]     mag_a, mag_b;
  logic [W:0]       sum;
  logic [2*W-1:0]   res;

  // Signed mode collapses to a constant 0 when the feature is compiled out.
  assign sm    = signed_mode & (SIGNED_EN != 0);
  // The most negative value negates to itself, which reads back as 2^(W-1).
  assign mag_a = (sm && a[W-1]) ? -a : a;
  assign mag_b = (sm && b[W-1]) ? -b : b;
  // Carry bit is always 0 here (cleared by the previous shift), so reading the
  // top W+1 bits of acc is the same as zero-extending the upper half.
  assign sum   = acc[2*W:W] + {1'b0, (acc[0] ? mcand : {W{1'b0}})};
  assign res   = neg ? -acc[2*W-1:0] : acc[2*W-1:0];
  assign busy  = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, W iterations in RUN, one result edge in FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(W-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, shift-add iteration, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= mag_a;
          acc   <= {1'b0, {W{1'b0}}, mag_b};
          cnt   <= '0;
          neg   <= sm & (a[W-1] ^ b[W-1]);
        end
        RUN: begin
          acc <= {1'b0, sum, acc[W-1:1]};
          cnt <= cnt + 1'b1;
        end
        FIN:     prod <= res;
        default: ;
      endcase
    end
  end

  // done pulses for the single cycle after the FIN edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == FIN);
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed bench for seq_mul_param: a W=16 signed-capable instance and a
// W=8 unsigned-only instance, table-driven products plus handshake sequences.
module tb_seq_mul_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mul_param #(.W(16), .SIGNED_EN(1)) u16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .prod(prod16));

  seq_mul_param #(.W(8), .SIGNED_EN(0)) u8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8));

  // done and busy must never be high together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((done16 && busy16) || (done8 && busy8)) begin
        errors++;
        $display("FAIL overlap: busy16=%0b done16=%0b busy8=%0b done8=%0b required no overlap",
                 busy16, done16, busy8, done8);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one W=16 operation and wait for done; reports product, latency,
  // and number of cycles busy was low while waiting.
  task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] p, output int lat, output int busy_low);
    @(negedge clk);
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0; busy_low = 0;
    while (!done16 && lat < 40) begin
      if (!busy16) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
    p = prod16;
  endtask

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec16_t;

  typedef struct {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] exp;
  } vec8_t;

  initial begin
    vec16_t      v16 [11];
    vec8_t       v8  [3];
    logic [31:0] p;
    int          lat, bl, ndone, cyc;

    v16[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    v16[1]  = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    v16[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    v16[3]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
    v16[4]  = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};
    v16[5]  = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000};
    v16[6]  = '{1'b0, 16'h00FF, 16'h0100, 32'h0000FF00};
    v16[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    v16[8]  = '{1'b0, 16'h8000, 16'h0002, 32'h00010000};
    v16[9]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
    v16[10] = '{1'b1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1};

    v8[0] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
    v8[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    v8[2] = '{1'b0, 8'h0D, 8'h0B, 16'h008F};

    // Reset state.
    #12;
    chk("rst_busy16", busy16, 0);
    chk("rst_done16", done16, 0);
    chk("rst_prod16", prod16, 0);
    chk("rst_busy8",  busy8,  0);
    chk("rst_done8",  done8,  0);
    chk("rst_prod8",  prod8,  0);
    @(negedge clk); reset = 1'b1;

    // Table of W=16 products.
    foreach (v16[i]) begin
      op16(v16[i].sm, v16[i].a, v16[i].b, p, lat, bl);
      chk($sformatf("v16_%0d_prod", i), p, v16[i].exp);
      chk($sformatf("v16_%0d_lat", i), lat, 17);
      chk($sformatf("v16_%0d_busy_run", i), bl, 0);
      chk($sformatf("v16_%0d_busy_done", i), busy16, 0);
      @(posedge clk); #1;
      chk($sformatf("v16_%0d_done_pulse", i), done16, 0);
      chk($sformatf("v16_%0d_prod_hold", i), prod16, v16[i].exp);
    end

    // Start re-pulsed while busy is ignored.
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'd7; b16 = 16'd6;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #1; start16 = 1'b1; a16 = 16'd1; b16 = 16'd1;
    @(posedge clk); #1;
    start16 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done16) begin
        ndone++;
        chk("ignore_prod", prod16, 42);
        chk("ignore_lat", c + 5, 17);
      end
      @(posedge clk); #1;
    end
    chk("ignore_ndone", ndone, 1);
    chk("ignore_busy", busy16, 0);

    // Back-to-back with start held: second operands presented at first done.
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'd3; b16 = 16'd4;
    @(posedge clk); #1;
    cyc = 0;
    while (!done16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("b2b_first_lat", cyc, 17);
    chk("b2b_first_prod", prod16, 12);
    a16 = 16'd5; b16 = 16'd5;
    @(posedge clk); #1;
    chk("b2b_done_drop", done16, 0);
    chk("b2b_busy_rise", busy16, 1);
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_prod_hold", prod16, 12);
    cyc = 6;
    while (!done16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("b2b_second_gap", cyc, 18);
    chk("b2b_second_prod", prod16, 25);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'd5;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (8) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    chk("arst_busy", busy16, 0);
    chk("arst_done", done16, 0);
    chk("arst_prod", prod16, 0);
    @(negedge clk); reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done16 || busy16) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    op16(1'b0, 16'd9, 16'd9, p, lat, bl);
    chk("arst_after_prod", p, 81);
    chk("arst_after_lat", lat, 17);

    // W=8 unsigned-only instance: signed_mode must be ignored.
    foreach (v8[i]) begin
      @(negedge clk);
      start8 = 1'b1; sm8 = v8[i].sm; a8 = v8[i].a; b8 = v8[i].b;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 30) begin @(posedge clk); #1; cyc++; end
      chk($sformatf("v8_%0d_prod", i), prod8, v8[i].exp);
      chk($sformatf("v8_%0d_lat", i), cyc, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
